// File: rtl/word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding and
// index register sizing.
package word_serializer_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    // A 1-word group still needs a 1-bit index register.
    function automatic int unsigned index_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Handshake bundle for the word serializer: parallel input side and narrow word output side.
interface word_serializer_if #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned WORD_COUNT = 4
) ();
    localparam int unsigned TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT;

    logic                   parallel_valid_i;
    logic                   parallel_ready_o;
    logic [TOTAL_WIDTH-1:0] parallel_i;
    logic                   word_valid_o;
    logic                   word_ready_i;
    logic [WORD_WIDTH-1:0]  word_o;
    logic                   last_o;
    logic                   busy_o;

    modport slave (
        input  parallel_valid_i,
        input  parallel_i,
        input  word_ready_i,
        output parallel_ready_o,
        output word_valid_o,
        output word_o,
        output last_o,
        output busy_o
    );

    modport master (
        output parallel_valid_i,
        output parallel_i,
        output word_ready_i,
        input  parallel_ready_o,
        input  word_valid_o,
        input  word_o,
        input  last_o,
        input  busy_o
    );

endinterface

// File: rtl/word_index_counter.sv
// Word index within the current parallel group; saturates at the last word and
// only returns to zero on an explicit clear.
module word_index_counter
    import word_serializer_pkg::*;
#(
    parameter int unsigned WORD_COUNT = 4,
    localparam int unsigned IndexWidth = index_width(WORD_COUNT)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  clear_i,
    input  logic                  incr_i,
    output logic [IndexWidth-1:0] index_o,
    output logic                  at_last_o
);

    localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(WORD_COUNT - 1);

    logic [IndexWidth-1:0] index_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_q <= '0;
        end else if (en_i) begin
            if (clear_i) begin
                index_q <= '0;
            end else if (incr_i && (index_q != LastIdx)) begin
                index_q <= index_q + 1'b1;
            end
        end
    end

    assign index_o   = index_q;
    assign at_last_o = (index_q == LastIdx);

endmodule

// File: rtl/word_serializer.sv
// Splits one wide parallel word into WORD_COUNT narrow words, one per output
// handshake, with no bubble between consecutive groups.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = 8,
    parameter int unsigned WORD_COUNT  = 4,
    parameter int unsigned TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT,
    parameter bit          LSB_FIRST   = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clk_en_i,
    word_serializer_if.slave  bus
);

    localparam int unsigned IndexWidth = index_width(WORD_COUNT);
    localparam logic [IndexWidth-1:0] LastIdx = IndexWidth'(WORD_COUNT - 1);

    state_e                 state_q;
    logic [TOTAL_WIDTH-1:0] shreg_q;
    logic [IndexWidth-1:0]  index;
    logic                   at_last;
    logic                   in_shift;
    logic                   take;
    logic                   capture;
    logic                   parallel_ready;

    assign in_shift = (state_q == StShift);
    assign take     = clk_en_i & in_shift & bus.word_ready_i;

    // word_ready_i -> parallel_ready_o is the one intended combinational path;
    // it lets the next group load while the last word leaves.
    assign parallel_ready = clk_en_i & (~in_shift | (at_last & bus.word_ready_i));
    assign capture        = parallel_ready & bus.parallel_valid_i;

    word_index_counter #(
        .WORD_COUNT (WORD_COUNT)
    ) u_index (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (clk_en_i),
        .clear_i   (capture),
        .incr_i    (take),
        .index_o   (index),
        .at_last_o (at_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            shreg_q <= '0;
        end else if (clk_en_i) begin
            if (capture) begin
                state_q <= StShift;
                shreg_q <= bus.parallel_i;
            end else if (take) begin
                if (at_last) begin
                    state_q <= StIdle;
                    shreg_q <= '0;
                end else begin
                    shreg_q <= LSB_FIRST ? (shreg_q >> WORD_WIDTH) : (shreg_q << WORD_WIDTH);
                end
            end
        end
    end

    assign bus.parallel_ready_o = parallel_ready;
    assign bus.word_valid_o     = clk_en_i & in_shift;
    assign bus.word_o           = LSB_FIRST ? shreg_q[WORD_WIDTH-1:0]
                                            : shreg_q[TOTAL_WIDTH-1 -: WORD_WIDTH];
    assign bus.last_o           = in_shift & (index == LastIdx);
    assign bus.busy_o           = in_shift;

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_word_serializer;

    localparam int unsigned W = 8;
    localparam int unsigned N = 4;

    typedef struct {
        logic [W-1:0] w;
        bit           last;
    } exp_t;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_en = 1'b1;

    int vectors     = 0;
    int miscompares = 0;

    word_serializer_if #(.WORD_WIDTH(W), .WORD_COUNT(N)) lb ();
    word_serializer_if #(.WORD_WIDTH(W), .WORD_COUNT(N)) mb ();

    word_serializer #(
        .WORD_WIDTH (W),
        .WORD_COUNT (N),
        .LSB_FIRST  (1'b1)
    ) dut_lsb (
        .clk_i    (clk),
        .rst_i    (rst),
        .clk_en_i (clk_en),
        .bus      (lb.slave)
    );

    word_serializer #(
        .WORD_WIDTH (W),
        .WORD_COUNT (N),
        .LSB_FIRST  (1'b0)
    ) dut_msb (
        .clk_i    (clk),
        .rst_i    (rst),
        .clk_en_i (clk_en),
        .bus      (mb.slave)
    );

    always #5 clk = ~clk;

    // Word k of a group, straight from the slice definition.
    function automatic logic [W-1:0] slice_of(input logic [W*N-1:0] v, input int k,
                                               input bit lsb);
        return lsb ? v[k*W +: W] : v[(N-1-k)*W +: W];
    endfunction

    // Drive point: 1 time unit after the rising edge; checks happen 4 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        #4;
        vectors++;
        if (lb.word_valid_o !== 1'b0 || lb.word_o !== 8'h00 || lb.last_o !== 1'b0 ||
            lb.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b w=%h l=%b b=%b want 0 00 0 0",
                     lb.word_valid_o, lb.word_o, lb.last_o, lb.busy_o);
        end
        vectors++;
        if (mb.word_o !== 8'h00 || mb.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_msb: got w=%h b=%b want 00 0", mb.word_o, mb.busy_o);
        end
        next_cycle();
        rst = 1'b0;
        #4;
        vectors++;
        if (lb.parallel_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 1", lb.parallel_ready_o);
        end
        next_cycle();
    endtask

    task automatic test_lsb_stream();
        logic [W-1:0] exp_w [N] = '{8'h11, 8'h22, 8'h33, 8'h44};
        lb.parallel_valid_i = 1'b1;
        lb.parallel_i       = 32'h44332211;
        lb.word_ready_i     = 1'b1;
        #4;
        vectors++;
        if (lb.parallel_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL lsb_accept: got ready=%b want 1", lb.parallel_ready_o);
        end
        next_cycle();
        lb.parallel_valid_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            #4;
            vectors++;
            if (lb.word_valid_o !== 1'b1 || lb.word_o !== exp_w[k] ||
                lb.last_o !== (k == N - 1)) begin
                miscompares++;
                $display("FAIL lsb_word[%0d]: got v=%b w=%h l=%b want 1 %h %b", k,
                         lb.word_valid_o, lb.word_o, lb.last_o, exp_w[k], (k == N - 1));
            end
            next_cycle();
        end
        #4;
        vectors++;
        if (lb.busy_o !== 1'b0 || lb.word_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL lsb_idle: got b=%b v=%b want 0 0", lb.busy_o, lb.word_valid_o);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_w [2*N] = '{8'h11, 8'h22, 8'h33, 8'h44,
                                      8'hAA, 8'hBB, 8'hCC, 8'hDD};
        lb.parallel_valid_i = 1'b1;
        lb.parallel_i       = 32'h44332211;
        lb.word_ready_i     = 1'b1;
        next_cycle();
        lb.parallel_i = 32'hDDCCBBAA;
        for (int k = 0; k < 2 * N; k++) begin
            #4;
            vectors++;
            if (lb.word_valid_o !== 1'b1 || lb.word_o !== exp_w[k] ||
                lb.parallel_ready_o !== ((k % N) == N - 1)) begin
                miscompares++;
                $display("FAIL b2b_word[%0d]: got v=%b w=%h r=%b want 1 %h %b", k,
                         lb.word_valid_o, lb.word_o, lb.parallel_ready_o, exp_w[k],
                         ((k % N) == N - 1));
            end
            next_cycle();
            if (k == N - 1) lb.parallel_valid_i = 1'b0;
        end
        #4;
        vectors++;
        if (lb.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_idle: got busy=%b want 0", lb.busy_o);
        end
        next_cycle();
    endtask

    task automatic test_msb_first();
        logic [W-1:0] exp_w [N] = '{8'h44, 8'h33, 8'h22, 8'h11};
        mb.parallel_valid_i = 1'b1;
        mb.parallel_i       = 32'h44332211;
        mb.word_ready_i     = 1'b1;
        next_cycle();
        mb.parallel_valid_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            #4;
            vectors++;
            if (mb.word_valid_o !== 1'b1 || mb.word_o !== exp_w[k] ||
                mb.last_o !== (k == N - 1)) begin
                miscompares++;
                $display("FAIL msb_word[%0d]: got v=%b w=%h l=%b want 1 %h %b", k,
                         mb.word_valid_o, mb.word_o, mb.last_o, exp_w[k], (k == N - 1));
            end
            next_cycle();
        end
        #4;
        vectors++;
        if (mb.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_idle: got busy=%b want 0", mb.busy_o);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_w [N] = '{8'h11, 8'h22, 8'h33, 8'h44};
        lb.parallel_valid_i = 1'b1;
        lb.parallel_i       = 32'h44332211;
        lb.word_ready_i     = 1'b1;
        next_cycle();
        lb.parallel_valid_i = 1'b0;
        next_cycle();
        lb.word_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #4;
            vectors++;
            if (lb.word_valid_o !== 1'b1 || lb.word_o !== 8'h22 || lb.last_o !== 1'b0 ||
                lb.parallel_ready_o !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b w=%h l=%b r=%b want 1 22 0 0", s,
                         lb.word_valid_o, lb.word_o, lb.last_o, lb.parallel_ready_o);
            end
            next_cycle();
        end
        lb.word_ready_i = 1'b1;
        for (int k = 1; k < N; k++) begin
            #4;
            vectors++;
            if (lb.word_o !== exp_w[k] || lb.last_o !== (k == N - 1)) begin
                miscompares++;
                $display("FAIL bp_resume[%0d]: got w=%h l=%b want %h %b", k, lb.word_o,
                         lb.last_o, exp_w[k], (k == N - 1));
            end
            next_cycle();
        end
    endtask

    task automatic test_clk_en();
        logic [W-1:0] exp_w [N] = '{8'h11, 8'h22, 8'h33, 8'h44};
        lb.parallel_valid_i = 1'b1;
        lb.parallel_i       = 32'h44332211;
        lb.word_ready_i     = 1'b1;
        next_cycle();
        lb.parallel_valid_i = 1'b0;
        next_cycle();
        clk_en              = 1'b0;
        lb.parallel_valid_i = 1'b1;
        lb.parallel_i       = 32'hDEADBEEF;
        for (int s = 0; s < 2; s++) begin
            #4;
            vectors++;
            if (lb.word_valid_o !== 1'b0 || lb.parallel_ready_o !== 1'b0 ||
                lb.word_o !== 8'h22) begin
                miscompares++;
                $display("FAIL clken_freeze[%0d]: got v=%b r=%b w=%h want 0 0 22", s,
                         lb.word_valid_o, lb.parallel_ready_o, lb.word_o);
            end
            next_cycle();
        end
        clk_en              = 1'b1;
        lb.parallel_valid_i = 1'b0;
        for (int k = 1; k < N; k++) begin
            #4;
            vectors++;
            if (lb.word_valid_o !== 1'b1 || lb.word_o !== exp_w[k]) begin
                miscompares++;
                $display("FAIL clken_resume[%0d]: got v=%b w=%h want 1 %h", k,
                         lb.word_valid_o, lb.word_o, exp_w[k]);
            end
            next_cycle();
        end
        #4;
        vectors++;
        if (lb.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL clken_idle: got busy=%b want 0", lb.busy_o);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_group();
        logic [W-1:0] exp_w [N] = '{8'h55, 8'h66, 8'h77, 8'h88};
        lb.parallel_valid_i = 1'b1;
        lb.parallel_i       = 32'h44332211;
        lb.word_ready_i     = 1'b1;
        next_cycle();
        lb.parallel_valid_i = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        #4;
        vectors++;
        if (lb.word_o !== 8'h33) begin
            miscompares++;
            $display("FAIL rstmid_pre: got w=%h want 33", lb.word_o);
        end
        next_cycle();
        rst = 1'b0;
        #4;
        vectors++;
        if (lb.word_valid_o !== 1'b0 || lb.word_o !== 8'h00 || lb.busy_o !== 1'b0 ||
            lb.parallel_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_post: got v=%b w=%h b=%b r=%b want 0 00 0 1",
                     lb.word_valid_o, lb.word_o, lb.busy_o, lb.parallel_ready_o);
        end
        next_cycle();
        lb.parallel_valid_i = 1'b1;
        lb.parallel_i       = 32'h88776655;
        next_cycle();
        lb.parallel_valid_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            #4;
            vectors++;
            if (lb.word_o !== exp_w[k] || lb.last_o !== (k == N - 1)) begin
                miscompares++;
                $display("FAIL rstmid_word[%0d]: got w=%h l=%b want %h %b", k, lb.word_o,
                         lb.last_o, exp_w[k], (k == N - 1));
            end
            next_cycle();
        end
    endtask

    // Model: the DUT is busy exactly while accepted words remain untaken.
    task automatic test_random();
        exp_t sb[$];
        bit   hold = 1'b0;
        bit   exp_busy, exp_vld, exp_rdy, take, accept;
        exp_t e;
        for (int c = 0; c < 400 + N + 1; c++) begin
            if (c >= 400) begin
                clk_en              = 1'b1;
                lb.word_ready_i     = 1'b1;
                lb.parallel_valid_i = 1'b0;
            end else begin
                clk_en          = ($urandom_range(0, 7) != 0);
                lb.word_ready_i = ($urandom_range(0, 3) != 0);
                if (!hold) begin
                    lb.parallel_valid_i = ($urandom_range(0, 2) != 0);
                    lb.parallel_i       = $urandom;
                end
            end
            #4;
            exp_busy = (sb.size() != 0);
            exp_vld  = clk_en && exp_busy;
            exp_rdy  = clk_en && (!exp_busy || (sb.size() == 1 && lb.word_ready_i));
            vectors++;
            if (lb.word_valid_o !== exp_vld || lb.parallel_ready_o !== exp_rdy ||
                lb.busy_o !== exp_busy) begin
                miscompares++;
                $display("FAIL rand_ctrl[%0d]: got v=%b r=%b b=%b want %b %b %b", c,
                         lb.word_valid_o, lb.parallel_ready_o, lb.busy_o, exp_vld, exp_rdy,
                         exp_busy);
            end
            if (exp_busy) begin
                vectors++;
                if (lb.word_o !== sb[0].w || lb.last_o !== sb[0].last) begin
                    miscompares++;
                    $display("FAIL rand_word[%0d]: got w=%h l=%b want %h %b", c, lb.word_o,
                             lb.last_o, sb[0].w, sb[0].last);
                end
            end
            take   = exp_vld && lb.word_ready_i;
            accept = exp_rdy && lb.parallel_valid_i;
            if (take) void'(sb.pop_front());
            if (accept) begin
                for (int k = 0; k < N; k++) begin
                    e.w    = slice_of(lb.parallel_i, k, 1'b1);
                    e.last = (k == N - 1);
                    sb.push_back(e);
                end
            end
            hold = lb.parallel_valid_i && !accept;
            next_cycle();
        end
        #4;
        vectors++;
        if (lb.busy_o !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_drain: got busy=%b want 0", lb.busy_o);
        end
        next_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        lb.parallel_valid_i = 1'b0;
        lb.parallel_i       = '0;
        lb.word_ready_i     = 1'b1;
        mb.parallel_valid_i = 1'b0;
        mb.parallel_i       = '0;
        mb.word_ready_i     = 1'b1;
        test_reset();
        test_lsb_stream();
        test_back_to_back();
        test_msb_first();
        test_backpressure();
        test_clk_en();
        test_reset_mid_group();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
